text_screen_controller: RTL and testbench



---
 rtl/text_screen_controller_pkg.sv | 38 +++
 rtl/text_screen_controller_if.sv | 26 ++
 rtl/text_screen_controller_screen_ram.sv | 27 ++
 rtl/text_screen_controller.sv | 157 +++++++++++++++
 tb/tb_text_screen_controller.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_screen_controller_pkg.sv
// Shared constants for the 40x15 text screen: grid geometry, control codes,
// controller state encoding and the glyph grid the pixel encoder maps onto.
package text_pkg;

    localparam int unsigned ROWS   = 15;
    localparam int unsigned COLS   = 40;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CELLS  = ROWS * COLS;

    localparam logic [7:0] BLANK_ID = 8'h20;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_CLEAR        = 2'd1;
    localparam logic [1:0] ST_SCROLL_COPY  = 2'd2;
    localparam logic [1:0] ST_SCROLL_BLANK = 2'd3;

    // Pixel encoder grid: each character cell is GLYPH_W x GLYPH_H pixels.
    localparam int unsigned GLYPH_W  = 16;
    localparam int unsigned GLYPH_H  = 32;
    localparam int unsigned SCREEN_W = COLS * GLYPH_W;
    localparam int unsigned SCREEN_H = ROWS * GLYPH_H;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_screen_controller_if.sv
// Byte-input handshake, encoder read port and status signals of the text
// screen controller; slave side is the controller itself.
interface text_screen_controller_if;
    import text_pkg::*;

    logic              in_valid;
    logic [7:0]        in_char;
    logic              in_ready;
    logic [ROW_W-1:0]  rd_row;
    logic [COL_W-1:0]  rd_col;
    logic [7:0]        rd_char_id;
    logic [ROW_W-1:0]  cursor_row;
    logic [COL_W-1:0]  cursor_col;
    logic              busy;

    modport master (
        output in_valid, in_char, rd_row, rd_col,
        input  in_ready, rd_char_id, cursor_row, cursor_col, busy
    );

    modport slave (
        input  in_valid, in_char, rd_row, rd_col,
        output in_ready, rd_char_id, cursor_row, cursor_col, busy
    );

endinterface

// File: rtl/text_screen_controller_screen_ram.sv
// ROWS*COLS x 8 character store: two asynchronous read ports (encoder and
// copy engine) and one synchronous write port, suited to distributed RAM.
module screen_ram
    import text_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [7:0]        rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [7:0]        rdata_b_o
);

    logic [7:0] mem_q [CELLS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/text_screen_controller.sv
// Text screen controller: byte-stream cursor engine with control codes,
// clear and scroll-up sweeps, plus the encoder's combinational read port.
module text_screen_controller
    import text_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    text_screen_controller_if.slave  bus
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] enc_addr;
    logic [7:0]        enc_data;
    logic [7:0]        copy_data;
    logic              last_row;

    assign cur_addr = cell_addr(row_q, col_q);
    assign enc_addr = cell_addr(bus.rd_row, bus.rd_col);
    assign last_row = (row_q == ROW_W'(ROWS - 1));

    screen_ram u_ram (
        .clk_i     (clk),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (enc_addr),
        .rdata_a_o (enc_data),
        .raddr_b_i (idx_q),
        .rdata_b_o (copy_data)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        we      = 1'b0;
        waddr   = cur_addr;
        wdata   = bus.in_char;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (is_printable(bus.in_char)) begin
                        we = 1'b1;
                        if (col_q < COL_W'(COLS - 1)) begin
                            col_d = col_q + COL_W'(1);
                        end else if (!last_row) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d   = '0;
                            idx_d   = ADDR_W'(COLS);
                            state_d = ST_SCROLL_COPY;
                        end
                    end else begin
                        case (bus.in_char)
                            CH_LF, CH_CR: begin
                                col_d = '0;
                                if (!last_row) begin
                                    row_d = row_q + ROW_W'(1);
                                end else begin
                                    idx_d   = ADDR_W'(COLS);
                                    state_d = ST_SCROLL_COPY;
                                end
                            end
                            CH_BS: begin
                                // Both cases land on the cell just before the cursor in linear order.
                                waddr = cur_addr - ADDR_W'(1);
                                wdata = BLANK_ID;
                                if (col_q != '0) begin
                                    we    = 1'b1;
                                    col_d = col_q - COL_W'(1);
                                end else if (row_q != '0) begin
                                    we    = 1'b1;
                                    row_d = row_q - ROW_W'(1);
                                    col_d = COL_W'(COLS - 1);
                                end
                            end
                            CH_FF: begin
                                row_d   = '0;
                                col_d   = '0;
                                idx_d   = '0;
                                state_d = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = idx_q;
                wdata = BLANK_ID;
                if (idx_q == ADDR_W'(CELLS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            ST_SCROLL_COPY: begin
                we    = 1'b1;
                waddr = idx_q - ADDR_W'(COLS);
                wdata = copy_data;
                if (idx_q == ADDR_W'(CELLS - 1)) begin
                    idx_d   = ADDR_W'((ROWS - 1) * COLS);
                    state_d = ST_SCROLL_BLANK;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                we    = 1'b1;
                waddr = idx_q;
                wdata = BLANK_ID;
                if (idx_q == ADDR_W'(CELLS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.cursor_row = row_q;
    assign bus.cursor_col = col_q;
    assign bus.rd_char_id = ((state_q == ST_CLEAR) ||
                             (bus.rd_row >= ROW_W'(ROWS)) ||
                             (bus.rd_col >= COL_W'(COLS))) ? BLANK_ID : enc_data;

endmodule

// File: tb/tb_text_screen_controller.sv
// Self-checking bench for text_screen_controller: directed scenarios plus a
// random byte stream compared against a row/column screen model.
module tb_text_screen_controller;
    import text_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    text_screen_controller_if bus ();

    text_screen_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    byte unsigned m_mem [ROWS][COLS];
    int m_row;
    int m_col;

    function automatic void m_blank_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_mem[r][c] = 8'h20;
    endfunction

    // Returns the number of busy cycles the byte should cause.
    function automatic int m_next_line();
        m_col = 0;
        if (m_row < ROWS - 1) begin
            m_row++;
            return 0;
        end
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                m_mem[r][c] = m_mem[r+1][c];
        for (int c = 0; c < COLS; c++)
            m_mem[ROWS-1][c] = 8'h20;
        return 600;
    endfunction

    function automatic int m_apply(input byte unsigned b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_mem[m_row][m_col] = b;
            if (m_col < COLS - 1) m_col++;
            else return m_next_line();
        end else if (b == 8'h0A || b == 8'h0D) begin
            return m_next_line();
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_mem[m_row][m_col] = 8'h20;
            end else if (m_row > 0) begin
                m_row--;
                m_col = COLS - 1;
                m_mem[m_row][m_col] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            m_blank_all();
            m_row = 0;
            m_col = 0;
            return 600;
        end
        return 0;
    endfunction

    task automatic read_cell(input int r, input int c, output logic [7:0] v);
        bus.rd_row = ROW_W'(r);
        bus.rd_col = COL_W'(c);
        #1;
        v = bus.rd_char_id;
    endtask

    task automatic check_cursor(input string name);
        checks++;
        if (bus.cursor_row !== ROW_W'(m_row) || bus.cursor_col !== COL_W'(m_col)) begin
            failures++;
            $display("FAIL %s cursor got (%0d,%0d) want (%0d,%0d)", name,
                     bus.cursor_row, bus.cursor_col, m_row, m_col);
        end
    endtask

    task automatic check_cell(input string name, input int r, input int c,
                              input logic [7:0] want);
        logic [7:0] v;
        read_cell(r, c, v);
        checks++;
        if (v !== want) begin
            failures++;
            $display("FAIL %s cell(%0d,%0d) got %h want %h", name, r, c, v, want);
        end
    endtask

    task automatic check_screen(input string name);
        logic [7:0] v;
        int bad;
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c, v);
                if (v !== m_mem[r][c]) begin
                    if (bad == 0)
                        $display("FAIL %s screen cell(%0d,%0d) got %h want %h",
                                 name, r, c, v, m_mem[r][c]);
                    bad++;
                end
            end
        checks++;
        if (bad != 0) failures++;
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name, output bit ok);
        int n;
        n = 0;
        while (!bus.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = bus.in_ready;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s ready_timeout got in_ready=0 want 1", name);
        end
    endtask

    task automatic send_byte(input byte unsigned b, input bit hold_valid);
        int n;
        int exp;
        bit ok;
        wait_ready("send", ok);
        if (!ok) return;
        bus.in_valid = 1'b1;
        bus.in_char  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp = m_apply(b);
        check_cursor("after_byte");
        checks++;
        if (bus.busy !== (exp > 0)) begin
            failures++;
            $display("FAIL busy_after_byte %h got %b want %b", b, bus.busy, exp > 0);
        end
        if (exp > 0) begin
            if (hold_valid) begin
                bus.in_valid = 1'b1;
                bus.in_char  = 8'h51;
            end
            n = 0;
            while (bus.busy && n < 2000) begin
                n++;
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
            checks++;
            if (n != exp) begin
                failures++;
                $display("FAIL busy_len byte %h got %0d want %0d", b, n, exp);
            end
        end
    endtask

    task automatic do_reset(input string name);
        int n;
        logic [7:0] v;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s in_reset busy/ready got %b/%b want 1/0", name, bus.busy, bus.in_ready);
        end
        read_cell(0, 0, v);
        checks++;
        if (v !== 8'h20) begin
            failures++;
            $display("FAIL %s read_in_reset got %h want 20", name, v);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (bus.busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 600) begin
            failures++;
            $display("FAIL %s clear_len got %0d want 600", name, n);
        end
        m_blank_all();
        m_row = 0;
        m_col = 0;
        check_cursor(name);
        check_screen(name);
        check_cell("oob_row", 15, 0, 8'h20);
        check_cell("oob_col", 0, 40, 8'h20);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.rd_row = '0;
        bus.rd_col = '0;
        do_reset("reset");
    endtask

    task automatic test_basic();
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        check_cell("basic_A", 0, 0, 8'h41);
        check_cell("basic_B", 0, 1, 8'h42);
        check_cursor("basic_ab");
        send_byte(8'h08, 1'b0);
        check_cell("basic_bs", 0, 1, 8'h20);
        check_cursor("basic_bs");
        check_cell("oob_after_text", 15, 0, 8'h20);
        @(negedge clk);
    endtask

    task automatic test_backspace_edges();
        send_byte(8'h0C, 1'b0);
        send_byte(8'h08, 1'b0);
        check_cursor("bs_origin");
        for (int i = 0; i < 39; i++) send_byte(8'h78, 1'b0);
        send_byte(8'h79, 1'b0);
        check_cell("wrap_y", 0, 39, 8'h79);
        check_cursor("wrap");
        send_byte(8'h08, 1'b0);
        check_cell("bs_prev_row", 0, 39, 8'h20);
        check_cursor("bs_prev_row");
        send_byte(8'h79, 1'b0);
        send_byte(8'h0D, 1'b0);
        check_cursor("cr");
        check_screen("bs_edges");
    endtask

    task automatic test_scroll();
        send_byte(8'h0C, 1'b0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!(r == ROWS - 1 && c == COLS - 1))
                    send_byte(8'h61 + r, 1'b0);
        check_cursor("scroll_pre");
        send_byte(8'h5A, 1'b1);
        check_cursor("scroll_post");
        check_cell("scroll_r0", 0, 0, 8'h62);
        check_cell("scroll_r12", 12, 5, 8'h6E);
        check_cell("scroll_Z", 13, 39, 8'h5A);
        check_cell("scroll_blank", 14, 20, 8'h20);
        check_screen("scroll");
    endtask

    task automatic test_random();
        byte unsigned b;
        int sel;
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
            else if (sel < 78) b = (sel < 74) ? 8'h0A : 8'h0D;
            else if (sel < 90) b = 8'h08;
            else if (sel < 92) b = 8'h0C;
            else begin
                b = 8'($urandom_range(0, 255));
                if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A ||
                    b == 8'h0C || b == 8'h0D)
                    b = 8'h7F;
            end
            send_byte(b, 1'b0);
            if (i % 60 == 59) check_screen("random");
        end
        check_screen("random_end");
    endtask

    task automatic test_reset_mid_scroll();
        bit ok;
        while (m_row < ROWS - 1) send_byte(8'h0A, 1'b0);
        wait_ready("mid_scroll", ok);
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h0A;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_scroll_busy got %b want 1", bus.busy);
        end
        repeat (100) @(negedge clk);
        do_reset("reset_mid_scroll");
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        bus.rd_row   = '0;
        bus.rd_col   = '0;
        reset        = 1'b1;
        m_row        = 0;
        m_col        = 0;
        m_blank_all();
        test_reset();
        test_basic();
        test_backspace_edges();
        test_scroll();
        test_random();
        test_reset_mid_scroll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
